// File: rtl/sub_seq_if.sv
// Operand/result handshake bundle for sub_seq.
// master drives operands and out_ready; slave is the subtractor.
interface sub_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, result, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, result, bout, ovf, zero
  );
endinterface

// File: rtl/sub_seq.sv
// Sequential subtractor: a - b - bin computed CHUNK bits per cycle over WIDTH/CHUNK cycles.
// Optional SUB_SEQ_SAT_EN clamps the result to 0 on unsigned underflow.
module sub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic       clk,
  input logic       rst,
  sub_seq_if.slave  bus
);
  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_diff;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_res_final;
  logic             w_last;
  logic             w_ovf;
  logic             w_zero;

  // Chunk select and merge are written as decoded loops to keep index arithmetic constant.
  always_comb begin
    w_a_chunk  = '0;
    w_b_chunk  = '0;
    w_res_next = r_res;
    for (int i = 0; i < int'(N); i++) begin
      if (r_k == KW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
    w_diff = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
    for (int i = 0; i < int'(N); i++) begin
      if (r_k == KW'(i)) begin
        w_res_next[i*CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
      end
    end
  end

  always_comb begin
    w_last = (r_k == KW'(N - 1));
    // Overflow uses the raw difference, before any saturation.
    w_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
`ifdef SUB_SEQ_SAT_EN
    w_res_final = w_diff[CHUNK] ? '0 : w_res_next;
`else
    w_res_final = w_res_next;
`endif
    w_zero = (w_res_final == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_k      <= '0;
            r_res    <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_borrow <= w_diff[CHUNK];
          r_k      <= r_k + 1'b1;
          if (w_last) begin
            r_res   <= w_res_final;
            r_bout  <= w_diff[CHUNK];
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
            r_state <= DONE;
          end else begin
            r_res   <= w_res_next;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_res;
  assign bus.bout      = r_bout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_sub_seq.sv
// Randomised self-checking bench for sub_seq (WIDTH=32, CHUNK=8) against an arithmetic model.
module tb_sub_seq;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sub_seq_if #(.WIDTH(WIDTH)) bus ();

  sub_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: one wide subtraction, borrow is the extra top bit.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                output logic [31:0] res, output logic bo, output logic ov,
                                output logic z);
    logic [32:0] d;
    d   = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    res = d[31:0];
    bo  = d[32];
    ov  = (a[31] != b[31]) && (res[31] != a[31]);
`ifdef SUB_SEQ_SAT_EN
    if (bo) res = '0;
`endif
    z   = (res == 32'd0);
  endfunction

  // Called at posedge+1 with the block idle; returns at posedge+1 with the block idle again.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input int hold);
    logic [31:0] e_res;
    logic        e_bo, e_ov, e_z;
    int          lat;
    model(a, b, bin, e_res, e_bo, e_ov, e_z);
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bin;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    lat = 0;
    // Garbage on the operand lines while busy must be ignored.
    do begin
      bus.in_valid = 1'($urandom % 2);
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.bin      = 1'($urandom % 2);
      check_eq("in_ready_busy", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    check_eq("latency", 64'(lat), 64'(N));
    check_eq("result", 64'(bus.result), 64'(e_res));
    check_eq("bout", 64'(bus.bout), 64'(e_bo));
    check_eq("ovf", 64'(bus.ovf), 64'(e_ov));
    check_eq("zero", 64'(bus.zero), 64'(e_z));
    check_eq("in_ready_done", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_result", 64'(bus.result), 64'(e_res));
      check_eq("hold_zero", 64'(bus.zero), 64'(e_z));
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    // in_valid high on the releasing edge must not start a new operation.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("release_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("release_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    check_eq("rst_flags", {61'd0, bus.bout, bus.ovf, bus.zero}, 64'd0);

    run_op(32'd5, 32'd3, 1'b0, 0);
    run_op(32'd3, 32'd5, 1'b0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 0);
    run_op(32'd0, 32'd0, 1'b1, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 5);

    // Abort mid-RUN with an asynchronous reset pulse.
    bus.a        = 32'h0000_00FF;
    bus.b        = 32'h0000_0001;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("abort_result", 64'(bus.result), 64'd0);
    check_eq("abort_flags", {61'd0, bus.bout, bus.ovf, bus.zero}, 64'd0);
    check_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("abort_no_output", 64'(seen), 64'd0);
    run_op(32'd10, 32'd4, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom % 4 == 0) ? ra : $urandom;
      run_op(ra, rb, 1'($urandom % 2), int'($urandom % 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sub_seq.md
SUB_SEQ -- requirements
Module: sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits subtracted per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand request.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 a  input  WIDTH  minuend.
REQ-009 b  input  WIDTH  subtrahend.
REQ-010 bin  input  1  borrow-in.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 result  output  WIDTH  a - b - bin, modulo 2^WIDTH (see REQ-031).
REQ-014 bout  output  1  borrow-out of the MSB (1 when a < b + bin, unsigned).
REQ-015 ovf  output  1  signed two's-complement overflow.
REQ-016 zero  output  1  result == 0.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 IDLE: on in_valid && in_ready at a clock edge, SHALL latch a, b and bin, clear the chunk index, and enter RUN.
REQ-020 RUN: each cycle SHALL subtract chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) using the borrow from chunk k-1 (bin for k=0), write the difference into the result register, store the chunk borrow, and increment k.
REQ-021 After the edge that processes chunk N-1, SHALL enter DONE; out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-022 DONE: result, bout, ovf and zero SHALL be held stable while out_ready is 0.
REQ-023 DONE with out_ready = 1 at an edge: SHALL return to IDLE; no new operand is accepted on that same edge.
REQ-024 in_valid SHALL be ignored in RUN and DONE, and latched operands SHALL NOT change.
REQ-025 bout SHALL be the borrow out of chunk N-1.
REQ-026 ovf SHALL be (a[MSB] != b[MSB]) && (raw result[MSB] != a[MSB]), computed on latched operands and the unsaturated result.
REQ-027 zero SHALL be computed on the final output value of result.
REQ-028 Values of result, bout, ovf and zero are defined only while out_valid = 1.
REQ-029 The minimum initiation interval SHALL be N + 2 cycles: accept, N in RUN, 1 in DONE.

Reset
REQ-030 rst = 1 SHALL immediately force IDLE, chunk index 0, in_ready 1 (after release), out_valid 0, and result, bout, ovf, zero and latched operands to 0. Reset during RUN or DONE SHALL abort the operation and produce no output.

Configuration
REQ-031 Macro SUB_SEQ_SAT_EN:
- Defined: unsigned saturation; when bout = 1, result SHALL be 0 and zero SHALL be 1. bout and ovf SHALL be unchanged.
- Undefined: result SHALL wrap modulo 2^WIDTH.

Verification (WIDTH=32, CHUNK=8, out_ready=1 unless stated)
REQ-032 a=5, b=3, bin=0 -> after 4 cycles out_valid=1, result=0x00000002, bout=0, ovf=0, zero=0.
REQ-033 a=3, b=5, bin=0 -> result=0xFFFFFFFE, bout=1 (with SUB_SEQ_SAT_EN: result=0, zero=1).
REQ-034 a=0x80000000, b=1, bin=0 -> result=0x7FFFFFFF, ovf=1, bout=0; a=0, b=0, bin=1 -> result=0xFFFFFFFF, bout=1, ovf=0.
REQ-035 a=0x12345678, b=0x12345678 with out_ready=0 for 5 cycles -> result=0, zero=1 held stable, in_ready=0 throughout; release out_ready -> IDLE on the next edge, then accept.
REQ-036 rst pulsed during cycle 2 of RUN -> out_valid=0 and all outputs 0; the next operation, a=10, b=4, yields result=6.
